// File: rtl/packet_types_pkg.sv
// Package packet_types: flit-level types shared by packet_flit_sender (transmit)
// and packet_buffer (receive).
//   DEFAULT_FLIT_DATA_WIDTH : default payload width of one flit
//   flit_type_t             : flit role within a packet
package packet_types;

    localparam int DEFAULT_FLIT_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'd0,
        FLIT_BODY     = 2'd1,
        FLIT_TAIL     = 2'd2,
        FLIT_HEADTAIL = 2'd3
    } flit_type_t;

endpackage

// File: rtl/packet_flit_sender.sv
// packet_flit_sender: latches one whole packet (header + up to MAX_BODY_FLITS body
// words) from the node core and serialises it as registered flits on the link side.
// Only one packet is in flight at a time.
//   clk, rst_n            clock, asynchronous active-low reset
//   pkt_valid/pkt_ready   packet handshake; pkt_header, pkt_body, pkt_len with it
//   flit_valid/flit_ready flit handshake; flit_type, flit_data, flit_seq with it
//   busy                  a packet is latched and not fully sent
//   len_err               one-cycle pulse after a packet with pkt_len > MAX_BODY_FLITS
module packet_flit_sender
    import packet_types::*;
#(
    parameter int FLIT_DATA_WIDTH = DEFAULT_FLIT_DATA_WIDTH,
    parameter int MAX_BODY_FLITS  = 7,
    parameter int LEN_WIDTH       = $clog2(MAX_BODY_FLITS + 1)
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            pkt_valid,
    output logic                                            pkt_ready,
    input  logic [FLIT_DATA_WIDTH-1:0]                      pkt_header,
    input  logic [MAX_BODY_FLITS-1:0][FLIT_DATA_WIDTH-1:0]  pkt_body,
    input  logic [LEN_WIDTH-1:0]                            pkt_len,
    output logic                                            flit_valid,
    input  logic                                            flit_ready,
    output flit_type_t                                      flit_type,
    output logic [FLIT_DATA_WIDTH-1:0]                      flit_data,
    output logic [LEN_WIDTH-1:0]                            flit_seq,
    output logic                                            busy,
    output logic                                            len_err
);

    typedef enum logic [1:0] {IDLE, SEND_HEAD, SEND_BODY} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_BODY_FLITS);
    localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

    state_t                                         state, state_nxt;
    logic [FLIT_DATA_WIDTH-1:0]                     hdr_r;
    logic [MAX_BODY_FLITS-1:0][FLIT_DATA_WIDTH-1:0] body_r;
    logic [LEN_WIDTH-1:0]                           len_r, idx, idx_nxt, idx_inc;

    logic                       accept, len_bad, flit_hs, last_body;
    logic                       fv_nxt;
    flit_type_t                 ft_nxt;
    logic [FLIT_DATA_WIDTH-1:0] fd_nxt;
    logic [LEN_WIDTH-1:0]       fs_nxt;

    assign pkt_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = pkt_valid && pkt_ready;
    assign len_bad   = (pkt_len > LEN_MAX);
    assign flit_hs   = flit_valid && flit_ready;
    assign idx_inc   = idx + ONE;
    // only meaningful in SEND_BODY, where len_r >= 1
    assign last_body = (idx == len_r - ONE);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (accept && !len_bad) state_nxt = SEND_HEAD;
            SEND_HEAD: if (flit_hs) state_nxt = (len_r == '0) ? IDLE : SEND_BODY;
            SEND_BODY: if (flit_hs && last_body) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // next flit values; loaded into the output registers so the following flit is
    // presented the cycle after a handshake with no bubble. Holds while stalled.
    always_comb begin
        fv_nxt  = flit_valid;
        ft_nxt  = flit_type;
        fd_nxt  = flit_data;
        fs_nxt  = flit_seq;
        idx_nxt = idx;
        unique case (state)
            IDLE: begin
                if (accept && !len_bad) begin
                    fv_nxt = 1'b1;
                    fd_nxt = pkt_header;
                    fs_nxt = '0;
                    ft_nxt = (pkt_len == '0) ? FLIT_HEADTAIL : FLIT_HEAD;
                end
            end
            SEND_HEAD: begin
                if (flit_hs) begin
                    idx_nxt = '0;
                    if (len_r == '0) begin
                        fv_nxt = 1'b0;
                    end else begin
                        fd_nxt = body_r[0];
                        fs_nxt = ONE;
                        ft_nxt = (len_r == ONE) ? FLIT_TAIL : FLIT_BODY;
                    end
                end
            end
            SEND_BODY: begin
                if (flit_hs) begin
                    idx_nxt = idx_inc;
                    if (last_body) begin
                        fv_nxt = 1'b0;
                    end else begin
                        fd_nxt = body_r[idx_inc];
                        fs_nxt = idx_inc + ONE;
                        ft_nxt = (idx_inc == len_r - ONE) ? FLIT_TAIL : FLIT_BODY;
                    end
                end
            end
            default: fv_nxt = 1'b0;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_r      <= '0;
            body_r     <= '0;
            len_r      <= '0;
            idx        <= '0;
            flit_valid <= 1'b0;
            flit_type  <= FLIT_HEAD;
            flit_data  <= '0;
            flit_seq   <= '0;
            len_err    <= 1'b0;
        end else begin
            // an oversize packet is consumed but never latched
            if (accept && !len_bad) begin
                hdr_r  <= pkt_header;
                body_r <= pkt_body;
                len_r  <= pkt_len;
            end
            idx        <= idx_nxt;
            flit_valid <= fv_nxt;
            flit_type  <= ft_nxt;
            flit_data  <= fd_nxt;
            flit_seq   <= fs_nxt;
            len_err    <= accept && len_bad;
        end
    end

endmodule

// File: tb/tb_packet_flit_sender.sv
module tb_packet_flit_sender;
    import packet_types::*;

    localparam int W    = 64;
    localparam int MAXB = 6;   // leaves pkt_len=7 representable as an oversize length
    localparam int LW   = 3;

    logic                      clk = 1'b0, rst_n = 1'b0;
    logic                      pkt_valid = 1'b0, pkt_ready;
    logic [W-1:0]              pkt_header = '0;
    logic [MAXB-1:0][W-1:0]    pkt_body = '0;
    logic [LW-1:0]             pkt_len = '0;
    logic                      flit_valid, flit_ready = 1'b1;
    flit_type_t                flit_type;
    logic [W-1:0]              flit_data;
    logic [LW-1:0]             flit_seq;
    logic                      busy, len_err;

    always #5 clk = ~clk;

    packet_flit_sender #(.FLIT_DATA_WIDTH(W), .MAX_BODY_FLITS(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_header(pkt_header),
        .pkt_body(pkt_body), .pkt_len(pkt_len),
        .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_type(flit_type),
        .flit_data(flit_data), .flit_seq(flit_seq), .busy(busy), .len_err(len_err)
    );

    typedef struct {flit_type_t t; logic [LW-1:0] s; logic [W-1:0] d; int c;} flit_t;
    typedef struct {int len; int mode; int exp_n; int exp_e;} vec_t;

    flit_t got[$], exp_q[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, err_seen = 0, exp_err = 0;
    int ready_mode = 0, stall_cnt = 0, acc_cyc = 0;
    bit hs_pend = 0, prev_stall = 0, prev_err = 0;
    flit_t prev;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: collects delivered flits, checks hold-under-stall and len_err pulse width
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0; prev_err = 0; hs_pend = 0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {flit_valid, flit_type, flit_seq, flit_data},
                    {1'b1, prev.t, prev.s, prev.d});
            if (len_err) begin
                err_seen++;
                chk("len_err_one_cycle", prev_err, 0);
            end
            prev_err   = len_err;
            hs_pend    = flit_valid && flit_ready;
            if (hs_pend) got.push_back('{flit_type, flit_seq, flit_data, cyc});
            prev_stall = flit_valid && !flit_ready;
            prev       = '{flit_type, flit_seq, flit_data, cyc};
        end
    end

    // downstream: 0 always ready, 1 random, 2 stall 3 cycles on every flit
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: flit_ready = 1'b1;
            1: flit_ready = ($urandom_range(0, 2) != 0);
            default: begin
                if (hs_pend) stall_cnt = 0;
                if (flit_valid && stall_cnt < 3) begin
                    flit_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    flit_ready = flit_valid;
                end
            end
        endcase
    end

    // reference: a packet becomes head followed by its body words in order
    function automatic void model_push(input logic [W-1:0] h, input logic [MAXB-1:0][W-1:0] b,
                                       input int len);
        if (len > MAXB) begin
            exp_err++;
            return;
        end
        exp_q.push_back('{(len == 0) ? FLIT_HEADTAIL : FLIT_HEAD, LW'(0), h, 0});
        for (int k = 1; k <= len; k++)
            exp_q.push_back('{(k == len) ? FLIT_TAIL : FLIT_BODY, LW'(k), b[k-1], 0});
    endfunction

    task automatic send_pkt(input logic [W-1:0] h, input logic [MAXB-1:0][W-1:0] b,
                            input int len, input bit model);
        int t = 0;
        @(posedge clk); #1;
        pkt_valid = 1'b1; pkt_header = h; pkt_body = b; pkt_len = LW'(len);
        @(negedge clk);
        while (!pkt_ready && t < 300) begin @(negedge clk); t++; end
        if (!pkt_ready) chk("accept_timeout", pkt_ready, 1);
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        if (model) model_push(h, b, len);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((got.size() < exp_q.size() || !pkt_ready) && t < 600) begin
            @(negedge clk); t++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_all();
        flit_t g, e;
        chk("flit_count", got.size(), exp_q.size());
        while (exp_q.size() > 0 && got.size() > 0) begin
            g = got.pop_front();
            e = exp_q.pop_front();
            chk("flit", {g.t, g.s, g.d}, {e.t, e.s, e.d});
        end
        got.delete(); exp_q.delete();
        chk("len_err_count", err_seen, exp_err);
    endtask

    function automatic logic [MAXB-1:0][W-1:0] rand_body();
        logic [MAXB-1:0][W-1:0] b;
        for (int k = 0; k < MAXB; k++) b[k] = {$urandom, $urandom};
        return b;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MAXB-1:0][W-1:0] b;
        vec_t tbl[6];
        int e0;

        // 1: reset state
        repeat (3) @(negedge clk);
        chk("rst_pkt_ready", pkt_ready, 1);
        chk("rst_flit_valid", flit_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_flit_type", flit_type, FLIT_HEAD);
        chk("rst_flit_data", flit_data, 0);
        chk("rst_flit_seq", flit_seq, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 2: len=3 back-to-back with timing
        b = '0; b[0] = 64'h11; b[1] = 64'h22; b[2] = 64'h33;
        send_pkt(64'hA5, b, 3, 1);
        @(negedge clk);
        chk("t2_latency_valid", flit_valid, 1);
        chk("t2_latency_type", flit_type, FLIT_HEAD);
        repeat (3) @(negedge clk);
        chk("t2_ready_during_tail", pkt_ready, 0);
        chk("t2_busy_during_tail", busy, 1);
        @(negedge clk);
        chk("t2_ready_after_tail", pkt_ready, 1);
        chk("t2_busy_after_tail", busy, 0);
        chk("t2_valid_after_tail", flit_valid, 0);
        for (int i = 0; i < got.size(); i++) chk("t2_flit_cycle", got[i].c, acc_cyc + i);
        wait_idle(); compare_all();

        // 3: len=0 -> HEADTAIL
        send_pkt(64'h5A, '0, 0, 1);
        @(negedge clk);
        chk("t3_type", flit_type, FLIT_HEADTAIL);
        wait_idle(); compare_all();

        // 4: len=2 with 3-cycle stall on each flit
        ready_mode = 2; stall_cnt = 0;
        send_pkt(64'hC0DE, rand_body(), 2, 1);
        wait_idle(); compare_all();
        ready_mode = 0;

        // 5: oversize length
        e0 = err_seen;
        send_pkt(64'hBAD, rand_body(), MAXB + 1, 1);
        @(negedge clk);
        chk("t5_len_err_high", len_err, 1);
        chk("t5_pkt_ready", pkt_ready, 1);
        chk("t5_no_flit", flit_valid, 0);
        @(negedge clk);
        chk("t5_len_err_low", len_err, 0);
        wait_idle();
        chk("t5_err_delta", err_seen - e0, 1);
        compare_all();

        // 6: reset after 2nd flit of len=5, then len=1 packet
        b = rand_body();
        send_pkt(64'h600D, b, 5, 1);
        repeat (4) void'(exp_q.pop_back());
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("t6_valid_in_reset", flit_valid, 0);
        chk("t6_busy_in_reset", busy, 0);
        chk("t6_ready_in_reset", pkt_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        send_pkt(64'h7777, rand_body(), 1, 1);
        wait_idle(); compare_all();

        // table-driven vectors: {len, ready mode, expected flit count, expected len_err}
        tbl[0] = '{0, 0, 1, 0};
        tbl[1] = '{1, 0, 2, 0};
        tbl[2] = '{MAXB, 0, MAXB + 1, 0};
        tbl[3] = '{MAXB + 1, 0, 0, 1};
        tbl[4] = '{3, 2, 4, 0};
        tbl[5] = '{MAXB, 1, MAXB + 1, 0};
        for (int i = 0; i < 6; i++) begin
            ready_mode = tbl[i].mode; stall_cnt = 0;
            e0 = err_seen;
            send_pkt({$urandom, $urandom}, rand_body(), tbl[i].len, 1);
            wait_idle();
            chk("vec_nflits", got.size(), tbl[i].exp_n);
            chk("vec_len_err", err_seen - e0, tbl[i].exp_e);
            compare_all();
        end

        // randomized stream against the reference model
        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            send_pkt({$urandom, $urandom}, rand_body(), $urandom_range(0, MAXB + 1), 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle(); compare_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
